// File: rtl/echo_width_meter_pkg.sv
// Shared telemeter constants and echo meter state encoding.
// Display and trigger blocks import the same defaults.
package echo_width_meter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam int DEF_CLK_PER_UNIT  = 147;
  localparam int DEF_OUT_W         = 8;
  localparam int DEF_MIN_VAL       = 6;
  localparam int DEF_MAX_VAL       = 254;
  localparam int DEF_TIMEOUT_UNITS = 255;

  function automatic logic [31:0] clamp_u(
    input logic [31:0] v,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    logic [31:0] r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/echo_width_meter_sync.sv
// Two-flop synchroniser with registered copy for edge detection.
// Reusable for echo, trigger and button inputs.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s1  <= d;
      s2  <= s1;
      s_d <= s2;
    end
  end

  assign rise = s2 & ~s_d;
  assign fall = ~s2 & s_d;

endmodule

// File: rtl/echo_width_meter.sv
// Armed single-shot echo width meter: counts synchronised high
// time in units of CLK_PER_UNIT clocks, clamps, flags timeouts.
module echo_width_meter
  import echo_width_meter_pkg::*;
#(
  parameter int CLK_PER_UNIT  = DEF_CLK_PER_UNIT,
  parameter int OUT_W         = DEF_OUT_W,
  parameter int MIN_VAL       = DEF_MIN_VAL,
  parameter int MAX_VAL       = DEF_MAX_VAL,
  parameter int TIMEOUT_UNITS = DEF_TIMEOUT_UNITS
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Mesure,
  input  logic             Start,
  output logic [OUT_W-1:0] Nb,
  output logic             Valid,
  output logic             Timeout,
  output logic             Busy
);

  localparam int PW = $clog2(CLK_PER_UNIT);
  localparam int UW = $clog2(TIMEOUT_UNITS + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_PER_UNIT - 1);
  localparam logic [PW-1:0] PRE_ONE   = PW'(1);
  localparam logic [UW-1:0] UNIT_LAST = UW'(TIMEOUT_UNITS - 1);
  localparam logic [OUT_W-1:0] NB_MAX = OUT_W'(MAX_VAL);

  state_t           state_q;
  state_t           state_d;
  logic [PW-1:0]    pre_q;
  logic [PW-1:0]    pre_d;
  logic [UW-1:0]    units_q;
  logic [UW-1:0]    units_d;
  logic             rise;
  logic             fall;
  logic             wrap;
  logic             hit;
  logic             to_d;
  logic [OUT_W-1:0] nb_d;
  logic             valid_d;
  logic             timeout_d;

  sync_edge_detect u_sync (
    .clk  (Clk),
    .rst  (Rst),
    .d    (Mesure),
    .rise (rise),
    .fall (fall)
  );

  assign wrap = (pre_q == PRE_LAST);
  // hit: this wrap would bring units up to the timeout limit
  assign hit  = wrap && (units_q == UNIT_LAST);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    units_d = units_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = WAIT_RISE;
          pre_d   = '0;
          units_d = '0;
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          state_d = MEASURE;
          pre_d   = PRE_ONE;
          units_d = '0;
        end else begin
          pre_d   = wrap ? '0 : pre_q + 1'b1;
          units_d = units_q + UW'(wrap);
          if (hit) begin
            state_d = DONE;
            to_d    = 1'b1;
          end
        end
      end
      MEASURE: begin
        // fall beats a same-cycle wrap so the result stays a floor
        if (fall) begin
          state_d = DONE;
        end else begin
          pre_d   = wrap ? '0 : pre_q + 1'b1;
          units_d = units_q + UW'(wrap);
          if (hit) begin
            state_d = DONE;
            to_d    = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    valid_d   = (state_d == DONE);
    timeout_d = to_d;
    nb_d      = Nb;
    if (state_d == DONE) begin
      nb_d = to_d ? NB_MAX :
        OUT_W'(clamp_u(32'(units_q), 32'(MIN_VAL), 32'(MAX_VAL)));
    end
    Busy = (state_q != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pre_q   <= '0;
      units_q <= '0;
      Nb      <= '0;
      Valid   <= 1'b0;
      Timeout <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      units_q <= units_d;
      Nb      <= nb_d;
      Valid   <= valid_d;
      Timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_echo_width_meter.sv
// Directed bench for echo_width_meter with CLK_PER_UNIT=4.
// Inputs driven and outputs sampled on the falling edge.
module tb_echo_width_meter;

  logic       Clk;
  logic       Rst;
  logic       Mesure;
  logic       Start;
  logic [7:0] Nb;
  logic       Valid;
  logic       Timeout;
  logic       Busy;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt  = 0;

  echo_width_meter #(
    .CLK_PER_UNIT  (4),
    .OUT_W         (8),
    .MIN_VAL       (6),
    .MAX_VAL       (254),
    .TIMEOUT_UNITS (255)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Mesure  (Mesure),
    .Start   (Start),
    .Nb      (Nb),
    .Valid   (Valid),
    .Timeout (Timeout),
    .Busy    (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) if (Valid === 1'b1) vcnt++;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic arm();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < budget) begin
      @(negedge Clk);
      n++;
      if (Valid === 1'b1) found = 1'b1;
    end
    if (!found) n = -1;
  endtask

  task automatic pulse(input int w, output int lat);
    repeat (3) @(negedge Clk);
    Mesure = 1'b1;
    repeat (w) @(negedge Clk);
    Mesure = 1'b0;
    wait_valid(20, lat);
  endtask

  task automatic measure(input string tag, input int w, input int exp_nb);
    int lat;
    arm();
    pulse(w, lat);
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_nb"}, 32'(Nb), exp_nb);
    chk({tag, "_to"}, 32'(Timeout), 0);
    @(negedge Clk);
    chk({tag, "_vend"}, 32'(Valid), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int v0;
    Rst    = 1'b1;
    Start  = 1'b0;
    Mesure = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_nb", 32'(Nb), 0);
    chk("rst_valid", 32'(Valid), 0);
    chk("rst_to", 32'(Timeout), 0);
    chk("rst_busy", 32'(Busy), 0);
    Rst = 1'b0;

    v0 = vcnt;
    measure("t1", 40, 10);
    chk("t1_busy", 32'(Busy), 0);
    chk("t1_vcnt", 32'(vcnt - v0), 1);

    measure("t2_43", 43, 10);
    measure("t2_12", 12, 6);
    measure("t2_1000", 1000, 250);
    measure("t2_1018", 1018, 254);

    arm();
    repeat (3) @(negedge Clk);
    Mesure = 1'b1;
    wait_valid(1100, n);
    chk("t3_cyc", n, 1022);
    chk("t3_nb", 32'(Nb), 254);
    chk("t3_to", 32'(Timeout), 1);
    Mesure = 1'b0;
    @(negedge Clk);
    chk("t3_to_clr", 32'(Timeout), 0);
    chk("t3_vend", 32'(Valid), 0);
    repeat (6) @(negedge Clk);
    chk("t3_idle", 32'(Busy), 0);

    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_valid(1100, n);
    if (n > 0) n = n + 1;
    chk("t4_cyc", n, 1021);
    chk("t4_nb", 32'(Nb), 254);
    chk("t4_to", 32'(Timeout), 1);

    Mesure = 1'b1;
    repeat (5) @(negedge Clk);
    v0 = vcnt;
    arm();
    repeat (30) @(negedge Clk);
    chk("t4b_busy", 32'(Busy), 1);
    chk("t4b_novalid", 32'(vcnt - v0), 0);
    Mesure = 1'b0;
    pulse(40, n);
    chk("t4b_lat", n, 3);
    chk("t4b_nb", 32'(Nb), 10);

    arm();
    repeat (3) @(negedge Clk);
    Mesure = 1'b1;
    repeat (20) @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (39) @(negedge Clk);
    Mesure = 1'b0;
    wait_valid(20, n);
    chk("t5a_lat", n, 3);
    chk("t5a_nb", 32'(Nb), 15);

    arm();
    repeat (3) @(negedge Clk);
    Mesure = 1'b1;
    repeat (20) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("t5b_nb", 32'(Nb), 0);
    chk("t5b_busy", 32'(Busy), 0);
    chk("t5b_valid", 32'(Valid), 0);
    v0 = vcnt;
    repeat (10) @(negedge Clk);
    Mesure = 1'b0;
    repeat (10) @(negedge Clk);
    chk("t5b_novalid", 32'(vcnt - v0), 0);
    chk("t5b_idle", 32'(Busy), 0);
    measure("t5c", 40, 10);

    arm();
    pulse(40, n);
    chk("t6a_lat", n, 3);
    chk("t6a_nb", 32'(Nb), 10);
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("t6_rearm", 32'(Busy), 1);
    repeat (3) @(negedge Clk);
    Mesure = 1'b1;
    repeat (80) @(negedge Clk);
    chk("t6_hold", 32'(Nb), 10);
    Mesure = 1'b0;
    wait_valid(20, n);
    chk("t6b_lat", n, 3);
    chk("t6b_nb", 32'(Nb), 20);
    chk("t6b_to", 32'(Timeout), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
